jt6295_mixinterp: RTL

- Parametrised channel mixer and upsampler for the ADPCM voice output path.
- Sums CH time-multiplexed voice samples per frame into a wide accumulator and latches the frame sum with optional saturation to OW bits.
- Upsamples the frame rate by 2^RATE_LOG with a linear interpolator.
- Generalises the fixed 4-voice/zero-stuff-filter mixer: channel count, widths and rate are parameters, and clipping is reported.

---
 rtl/jt6295_mixinterp.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/jt6295_mixinterp.sv
// ----------------------------------------------------------------------------
// jt6295_mixinterp
//
// Channel mixer and linear-interpolating upsampler for the ADPCM voice path.
// CH time-multiplexed voice samples are summed into an AW-bit accumulator
// once per frame. On each frame strobe the sum is fitted to OW bits and latched.
// The output then ramps linearly from the previous frame value to the new one
// in 2^RATE_LOG steps, one step per output-rate strobe.
//
// Optional feature (macro JT6295_MIXINTERP_SAT_EN):
//   defined   : the frame sum is clamped to the OW-bit signed range and clip
//               pulses for one cycle after each frame strobe that clamped
//   undefined : the frame sum wraps (two's complement) to OW bits; clip = 0
//
// Ports:
//   rst        in  asynchronous reset, active-high
//   clk        in  clock
//   cen        in  frame strobe, one per input-rate sample
//   cen_ch     in  voice slot strobe, CH per frame; first slot coincides with cen
//   sound_in   in  IW-bit signed voice sample, valid when cen_ch=1
//   cen_out    in  output-rate strobe, 2^RATE_LOG per frame; one coincides with cen
//   sound_out  out OW-bit signed interpolated output
//   clip       out one-cycle pulse for a frame sum that saturated
// ----------------------------------------------------------------------------
module jt6295_mixinterp #(
    parameter int IW       = 12,
    parameter int CH       = 4,
    parameter int AW       = 16,
    parameter int OW       = 14,
    parameter int RATE_LOG = 2
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 cen,
    input  logic                 cen_ch,
    input  logic signed [IW-1:0] sound_in,
    input  logic                 cen_out,
    output logic signed [OW-1:0] sound_out,
    output logic                 clip
);

    localparam int SW = $clog2(CH + 1);          // slot counter holds 0..CH
    localparam int RW = OW + 1 + RATE_LOG;       // ramp keeps RATE_LOG fraction bits

    localparam logic [RATE_LOG-1:0] PH_MAX = '1;
    localparam logic [SW-1:0]       SLOTS  = SW'(CH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic signed [AW-1:0] r_acc;
    logic        [SW-1:0] r_slot;
    logic signed [OW-1:0] r_cur;
    logic signed [OW-1:0] r_base;
    logic signed [OW:0]   r_delta;
    logic signed [RW-1:0] r_ramp;
    logic [RATE_LOG-1:0]  r_phase;
    logic signed [OW-1:0] r_sound_out;
    logic                 r_clip;

    // ------------------------------------------------------------------------
    // Frame fit: saturate or wrap the accumulator to OW bits
    // ------------------------------------------------------------------------
    logic signed [AW-1:0] w_sample;
    logic signed [OW-1:0] w_fit;
    logic                 w_clip_set;

    assign w_sample = AW'(sound_in);   // signed operand: size cast sign-extends

`ifdef JT6295_MIXINTERP_SAT_EN
    logic [AW-OW:0] w_top;
    logic           w_ovf;

    // The sum fits in OW bits exactly when every bit from the OW-bit sign
    // position upwards agrees.
    assign w_top      = r_acc[AW-1:OW-1];
    assign w_ovf      = ~((&w_top) | ~(|w_top));
    assign w_fit      = !w_ovf       ? r_acc[OW-1:0] :
                        r_acc[AW-1]  ? {1'b1, {(OW-1){1'b0}}} :
                                       {1'b0, {(OW-1){1'b1}}};
    assign w_clip_set = w_ovf;
`else
    assign w_fit      = r_acc[OW-1:0];
    assign w_clip_set = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Interpolator datapath. On a cen cycle the frame latch happens first, so
    // the values a simultaneous cen_out step uses are the post-latch ones:
    // base = old cur, ramp = 0, phase = 0, delta = freshly computed delta.
    // ------------------------------------------------------------------------
    logic signed [OW:0]   w_delta_new;
    logic signed [OW-1:0] w_base_eff;
    logic signed [OW:0]   w_delta_eff;
    logic signed [RW-1:0] w_ramp_eff;
    logic [RATE_LOG-1:0]  w_phase_eff;
    logic signed [OW-1:0] w_interp;
    logic signed [RW-1:0] w_ramp_step;

    assign w_delta_new = {w_fit[OW-1], w_fit} - {r_cur[OW-1], r_cur};

    assign w_base_eff  = cen ? r_cur       : r_base;
    assign w_delta_eff = cen ? w_delta_new : r_delta;
    assign w_ramp_eff  = cen ? '0          : r_ramp;
    assign w_phase_eff = cen ? '0          : r_phase;

    // base + (ramp >>> RATE_LOG) truncated to OW bits. Only the low OW bits of
    // the shifted ramp can influence a truncated OW-bit sum.
    assign w_interp    = w_base_eff + w_ramp_eff[OW-1+RATE_LOG:RATE_LOG];
    assign w_ramp_step = w_ramp_eff + RW'(w_delta_eff);

    // ------------------------------------------------------------------------
    // Accumulator. Excess slots beyond CH in a frame are ignored.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_slot <= '0;
        end else if (cen) begin
            r_acc  <= cen_ch ? w_sample : '0;
            r_slot <= cen_ch ? SW'(1)   : '0;
        end else if (cen_ch && (r_slot < SLOTS)) begin
            r_acc  <= r_acc + w_sample;
            r_slot <= r_slot + SW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Frame latch and interpolator
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur       <= '0;
            r_base      <= '0;
            r_delta     <= '0;
            r_ramp      <= '0;
            r_phase     <= '0;
            r_sound_out <= '0;
            r_clip      <= 1'b0;
        end else begin
            r_clip <= cen & w_clip_set;

            if (cen) begin
                r_cur   <= w_fit;
                r_base  <= r_cur;
                r_delta <= w_delta_new;
            end

            // The last step of a frame still produces an output but leaves the
            // ramp alone, so extra cen_out pulses repeat that value.
            if (cen_out) begin
                r_sound_out <= w_interp;
                if (w_phase_eff != PH_MAX) begin
                    r_ramp  <= w_ramp_step;
                    r_phase <= w_phase_eff + 1'b1;
                end else begin
                    r_ramp  <= w_ramp_eff;
                    r_phase <= w_phase_eff;
                end
            end else begin
                r_ramp  <= w_ramp_eff;
                r_phase <= w_phase_eff;
            end
        end
    end

    assign sound_out = r_sound_out;
    assign clip      = r_clip;

endmodule
